// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter and the DM block.
package dm_port_arbiter_pkg;

  localparam int unsigned DM_DATA_W = 16;
  localparam int unsigned DM_ADDR_W = 16;

  // Owner of the read data returning from the memory this cycle.
  typedef enum logic [1:0] {
    R_NONE = 2'd0,
    R_CORE = 2'd1,
    R_HOST = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bus bundle for the DM port arbiter: core side, host side and memory macro side.
// host_lock exists only when ARB_HOST_LOCK_EN is defined.
interface dm_port_arbiter_if
  import dm_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DM_DATA_W,
  parameter int unsigned ADDR_W = DM_ADDR_W
) ();

  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_stall;
  logic [DATA_W-1:0] core_rdata;
  logic              core_rvalid;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
`ifdef ARB_HOST_LOCK_EN
  logic              host_lock;
`endif

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters and memory model side.
  modport master (
`ifdef ARB_HOST_LOCK_EN
    output host_lock,
`endif
    output core_req, core_we, core_addr, core_wdata,
    input  core_stall, core_rdata, core_rvalid,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  // Arbiter side.
  modport slave (
`ifdef ARB_HOST_LOCK_EN
    input  host_lock,
`endif
    input  core_req, core_we, core_addr, core_wdata,
    output core_stall, core_rdata, core_rvalid,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/dm_starve_ctr.sv
// Host starvation counter: counts consecutive waiting cycles and raises
// force_grant once the host has waited STARVE_MAX cycles.
module dm_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  input  logic clr,
  output logic force_grant
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;

  // Saturating count of host wait cycles; any grant or dropped request restarts it.
  always_ff @(posedge clk) begin
    if (reset || clr || !req || gnt) begin
      cnt_q <= '0;
    end else if (cnt_q != MaxCnt) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Force a host grant once the wait limit is reached.
  always_comb begin
    force_grant = req && (cnt_q == MaxCnt);
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: core has fixed priority, the host is guaranteed
// progress by a starvation counter. Optional macro ARB_HOST_LOCK_EN adds a
// host lock that keeps the port for atomic host read-modify-write.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = DM_DATA_W,
  parameter int unsigned ADDR_W     = DM_ADDR_W,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 8
) (
  input logic              clk,
  input logic              reset,
  dm_port_arbiter_if.slave bus
);

  rd_owner_e         rd_owner_q;
  logic              hold_q;
  logic              active;
  logic              host_req_eff;
  logic              force_host;
  logic              locked;
  logic              core_gnt;
  logic              host_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Keeps all grants off for the first cycle after reset as well as during it.
  always_ff @(posedge clk) begin
    hold_q <= reset;
  end

`ifdef ARB_HOST_LOCK_EN
  logic lock_q;

  // Lock is taken on a host grant with host_lock set and dropped with host_lock.
  always_ff @(posedge clk) begin
    if (reset || !bus.host_lock) begin
      lock_q <= 1'b0;
    end else if (host_gnt) begin
      lock_q <= 1'b1;
    end
  end

  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

  assign active       = !reset && !hold_q;
  assign host_req_eff = active && bus.host_req;

  dm_starve_ctr #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_starve (
    .clk         (clk),
    .reset       (reset),
    .req         (host_req_eff),
    .gnt         (host_gnt),
    .clr         (locked),
    .force_grant (force_host)
  );

  // Grant decision and memory mux; only one side can win in a cycle.
  always_comb begin
    core_gnt  = active && bus.core_req && !force_host && !locked;
    host_gnt  = host_req_eff && (!bus.core_req || force_host || locked);
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_en    = 1'b1;
      mem_we    = bus.core_we;
      mem_addr  = bus.core_addr;
      mem_wdata = bus.core_wdata;
    end else if (host_gnt) begin
      mem_en    = 1'b1;
      mem_we    = bus.host_we;
      mem_addr  = bus.host_addr;
      mem_wdata = bus.host_wdata;
    end
  end

  // Read-return FSM: remembers who issued the read whose data arrives next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_q <= R_NONE;
    end else if (core_gnt && !bus.core_we) begin
      rd_owner_q <= R_CORE;
    end else if (host_gnt && !bus.host_we) begin
      rd_owner_q <= R_HOST;
    end else begin
      rd_owner_q <= R_NONE;
    end
  end

  // Drive the bus; rvalid is masked during reset so an in-flight read is dropped.
  always_comb begin
    bus.mem_en      = mem_en;
    bus.mem_we      = mem_we;
    bus.mem_addr    = mem_addr;
    bus.mem_wdata   = mem_wdata;
    bus.core_stall  = active && bus.core_req && !core_gnt;
    bus.host_gnt    = host_gnt;
    bus.core_rvalid = !reset && (rd_owner_q == R_CORE);
    bus.host_rvalid = !reset && (rd_owner_q == R_HOST);
    bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : '0;
    bus.host_rdata  = bus.host_rvalid ? bus.mem_rdata : '0;
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port 16-bit data memory between two requesters: the pipeline's DM stage ("core") and an external host/DMA port ("host").
- Core has fixed priority. A starvation counter forces a host grant, stalling the core for that one cycle, so the host always makes progress.
- Sits between the DM-stage control (mem_en/mem_rw, address, store data) and the memory macro, and returns read data to whichever side issued the read.

Parameters:
- DATA_W, 16, data width of the memory and both requesters.
- ADDR_W, 16, address width.
- STARVE_MAX, 4, consecutive host wait cycles before a forced host grant; legal range 1..255.
- CNT_W, 8, width of the starvation counter; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  core access request (DM-stage mem_en).
- core_we  in  1  1 = store, 0 = load (DM-stage mem_rw).
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core store data.
- core_stall  out  1  core access refused this cycle; the pipeline freezes and re-presents the request.
- core_rdata  out  DATA_W  core load data.
- core_rvalid  out  1  core_rdata valid.
- host_req  in  1  host request; must be held with stable signals until host_gnt.
- host_we  in  1  host write enable.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host request accepted this cycle.
- host_rdata  out  DATA_W  host read data.
- host_rvalid  out  1  host_rdata valid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; synchronous, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Grant decision is combinational in cycle t:
  - force = host_req && (starve_cnt == STARVE_MAX).
  - The core is granted if core_req && !force.
  - The host is granted if host_req && (!core_req || force).
  - At most one grant per cycle.
- Memory mux:
  - mem_en = any grant.
  - mem_we, mem_addr and mem_wdata come from the granted side.
  - With no grant: mem_en=0, mem_we=0, and mem_addr/mem_wdata = 0.
- Stall and grant outputs:
  - core_stall = core_req && !core grant. It is combinational, so the pipeline freezes in the same cycle.
  - host_gnt = host grant (combinational, one pulse per accepted access).
- Read return FSM (rd_owner register), states R_NONE, R_CORE, R_HOST:
  - Next state: R_CORE on a core read grant, R_HOST on a host read grant, otherwise R_NONE.
  - core_rvalid = (rd_owner == R_CORE); host_rvalid = (rd_owner == R_HOST).
  - Both rdata outputs mirror mem_rdata only while their rvalid is high, and are 0 otherwise.
  - Load latency is 1 cycle after the grant. Writes produce no rvalid.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_MAX) each cycle host_req=1 && host_gnt=0.
  - It clears to 0 on host_gnt, or when host_req=0.
- Boundary cases:
  - core_req=0 with host_req=1 grants the host immediately; the counter stays 0.
  - If host_req drops before a grant (a protocol violation), the counter clears and no access occurs.
  - A core access stalled by force is re-presented by the pipeline and is granted next cycle unless force recurs. Force cannot recur, because the counter cleared on the forced grant.
- Reset:
  - starve_cnt=0 and rd_owner=R_NONE.
  - All outputs are 0 in the reset cycle and the cycle after it: core_stall=0, grants=0, mem_en=0.
  - Requests are ignored while reset=1.
  - A read granted in the cycle before reset asserts returns no rvalid.

Optional Feature:
- Macro ARB_HOST_LOCK_EN.
- With the macro defined:
  - Adds input host_lock (1 bit) and register lock_q.
  - lock_q sets on a host grant with host_lock=1 and clears when host_lock=0, or on reset.
  - While lock_q=1: the host is granted whenever host_req=1 regardless of core_req; the core is never granted (core_stall = core_req); starve_cnt is held at 0.
  - This supports atomic host read-modify-write.
- Without the macro: no host_lock port and no lock_q register; behaviour is exactly as described above.

Decomposition:
- Shared package: rd_owner state encoding (R_NONE=2'd0, R_CORE=2'd1, R_HOST=2'd2) and default DATA_W/ADDR_W constants shared with the DM block.
- One natural sub-module: dm_starve_ctr (saturating counter plus force compare, parameterised by STARVE_MAX/CNT_W). Everything else stays in dm_port_arbiter.

Test Plan:
- Core only: core_req=1, core_we=0, addr=0x0010; memory returns 0xBEEF next cycle → mem_en=1 at t; core_rvalid=1 with core_rdata=0xBEEF at t+1; core_stall=0 throughout.
- Host only: host_req=1, host_we=1, addr=0x0020, wdata=0x1234 → host_gnt=1 at t; mem_we=1, mem_addr=0x0020, mem_wdata=0x1234 at t; no rvalid at t+1.
- Contention with STARVE_MAX=4: core_req and host_req both held high; host read at 0x0030 → core granted at t..t+3; at t+4 host_gnt=1 and core_stall=1; host_rvalid=1 at t+5; starve_cnt=0 at t+5.
- Back-to-back mixed reads: core read at t, host read at t+1 (core idle) → core_rvalid at t+1, host_rvalid at t+2; each rdata matches its own address; the other rvalid stays 0.
- Reset mid-operation: core read granted at t, reset=1 at t+1 → core_rvalid=0 at t+1 and t+2; starve_cnt=0; all mem_* outputs 0.
- ARB_HOST_LOCK_EN: host read granted with host_lock=1, then core_req=1 for 3 cycles while lock is held → core_stall=1 for all 3 cycles; host write is granted despite core_req; host_lock=0 → core is granted the next cycle.
